// File: rtl/freq_sweep_pkg.sv
// freq_sweep_pkg: shared types and default widths for the frequency-sweep
// (chirp) controller.
//   state_e : controller state (IDLE, SWEEP, LAST)
//   dir_e   : sweep direction, latched when a sweep starts
package freq_sweep_pkg;

    localparam int PHASE_W_DEF = 32;
    localparam int DWELL_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        LAST  = 2'd2
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/freq_sweep_dwell_timer.sv
// freq_sweep_dwell_timer: loadable down-counter that sets how long each
// increment value is held.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : force the count to 0 (highest priority)
//   load_i       : load load_val_i
//   load_val_i   : dwell reload value
//   en_i         : count enable
//   expire_o     : high for the single cycle the enabled count sits at 0.
//                  The owner reloads on that cycle, so it is a one-cycle pulse.
module freq_sweep_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: frequency-sweep (chirp) controller. It steps the phase
// increment fed to the phase accumulator from f_start to f_stop in f_step
// increments and holds each value for dwell+1 cycles.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   start_i / stop_i  : start pulse (only taken in IDLE), abort pulse
//   f_start_i, f_stop_i, f_step_i, dwell_i, repeat_i : sweep configuration,
//                       latched when a start is accepted
//   tri_i             : triangle mode (present only with FREQ_SWEEP_TRIANGLE_EN)
//   phase_inc_o       : registered increment to the phase accumulator
//   busy_o            : high in SWEEP or LAST
//   step_o, done_o, wrap_o : one-cycle status pulses
// Build option: define FREQ_SWEEP_TRIANGLE_EN to add tri_i. With repeat and
// tri both set, each LAST expiry swaps start/stop and reverses direction.
module freq_sweep_ctrl
    import freq_sweep_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [PHASE_W-1:0] f_start_i,
    input  logic [PHASE_W-1:0] f_stop_i,
    input  logic [PHASE_W-1:0] f_step_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               repeat_i,
`ifdef FREQ_SWEEP_TRIANGLE_EN
    input  logic               tri_i,
`endif
    output logic [PHASE_W-1:0] phase_inc_o,
    output logic               busy_o,
    output logic               step_o,
    output logic               done_o,
    output logic               wrap_o
);

    state_e               state_q, state_d;
    dir_e                 dir_q, dir_d;
    logic [PHASE_W-1:0]   f_start_q, f_start_d;
    logic [PHASE_W-1:0]   f_stop_q, f_stop_d;
    logic [PHASE_W-1:0]   f_step_q, f_step_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 repeat_q, repeat_d;
    logic [PHASE_W-1:0]   phase_inc_q, phase_inc_d;
    logic                 busy_q, busy_d;
    logic                 step_q, step_d;
    logic                 done_q, done_d;
    logic                 wrap_q, wrap_d;
`ifdef FREQ_SWEEP_TRIANGLE_EN
    logic                 tri_q, tri_d;
`endif

    logic                 tmr_clr, tmr_load, tmr_exp;
    logic [DWELL_W-1:0]   tmr_val;

    // One extra bit so a step past either end of the range shows up as
    // carry/borrow instead of wrapping around to a small or large value.
    logic [PHASE_W:0]     next_ext;
    logic                 clamp;

    freq_sweep_dwell_timer #(.W(DWELL_W)) u_dwell (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (busy_q),
        .expire_o   (tmr_exp)
    );

    always_comb begin
        if (dir_q == DIR_UP) begin
            next_ext = {1'b0, phase_inc_q} + {1'b0, f_step_q};
            clamp    = next_ext[PHASE_W] || (next_ext[PHASE_W-1:0] >= f_stop_q);
        end else begin
            next_ext = {1'b0, phase_inc_q} - {1'b0, f_step_q};
            clamp    = next_ext[PHASE_W] || (next_ext[PHASE_W-1:0] <= f_stop_q);
        end
        // A zero step would never get anywhere, so go straight to f_stop.
        if (f_step_q == '0) clamp = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        f_start_d   = f_start_q;
        f_stop_d    = f_stop_q;
        f_step_d    = f_step_q;
        dwell_d     = dwell_q;
        repeat_d    = repeat_q;
        phase_inc_d = phase_inc_q;
        busy_d      = busy_q;
        step_d      = 1'b0;
        done_d      = 1'b0;
        wrap_d      = 1'b0;
`ifdef FREQ_SWEEP_TRIANGLE_EN
        tri_d       = tri_q;
`endif
        tmr_clr     = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = dwell_q;

        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    f_start_d   = f_start_i;
                    f_stop_d    = f_stop_i;
                    f_step_d    = f_step_i;
                    dwell_d     = dwell_i;
                    repeat_d    = repeat_i;
`ifdef FREQ_SWEEP_TRIANGLE_EN
                    tri_d       = tri_i;
`endif
                    dir_d       = (f_stop_i >= f_start_i) ? DIR_UP : DIR_DOWN;
                    phase_inc_d = f_start_i;
                    busy_d      = 1'b1;
                    step_d      = 1'b1;
                    tmr_load    = 1'b1;
                    tmr_val     = dwell_i;
                    state_d     = (f_start_i == f_stop_i) ? LAST : SWEEP;
                end
            end

            SWEEP: begin
                if (stop_i) begin
                    busy_d  = 1'b0;
                    tmr_clr = 1'b1;
                    state_d = IDLE;
                end else if (tmr_exp) begin
                    step_d   = 1'b1;
                    tmr_load = 1'b1;
                    if (clamp) begin
                        phase_inc_d = f_stop_q;
                        state_d     = LAST;
                    end else begin
                        phase_inc_d = next_ext[PHASE_W-1:0];
                    end
                end
            end

            LAST: begin
                if (stop_i) begin
                    busy_d  = 1'b0;
                    tmr_clr = 1'b1;
                    state_d = IDLE;
                end else if (tmr_exp) begin
                    if (!repeat_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        tmr_clr = 1'b1;
                        state_d = IDLE;
                    end else begin
                        step_d   = 1'b1;
                        wrap_d   = 1'b1;
                        tmr_load = 1'b1;
                        state_d  = (f_start_q == f_stop_q) ? LAST : SWEEP;
`ifdef FREQ_SWEEP_TRIANGLE_EN
                        if (tri_q) begin
                            // Reverse: the old stop becomes the new start.
                            // phase_inc keeps its value and the next dwell
                            // expiry steps away from it.
                            f_start_d   = f_stop_q;
                            f_stop_d    = f_start_q;
                            dir_d       = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                            phase_inc_d = f_stop_q;
                        end else begin
                            phase_inc_d = f_start_q;
                        end
`else
                        phase_inc_d = f_start_q;
`endif
                    end
                end
            end

            default: begin
                busy_d  = 1'b0;
                tmr_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            dir_q       <= DIR_UP;
            f_start_q   <= '0;
            f_stop_q    <= '0;
            f_step_q    <= '0;
            dwell_q     <= '0;
            repeat_q    <= 1'b0;
            phase_inc_q <= '0;
            busy_q      <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
`ifdef FREQ_SWEEP_TRIANGLE_EN
            tri_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            f_start_q   <= f_start_d;
            f_stop_q    <= f_stop_d;
            f_step_q    <= f_step_d;
            dwell_q     <= dwell_d;
            repeat_q    <= repeat_d;
            phase_inc_q <= phase_inc_d;
            busy_q      <= busy_d;
            step_q      <= step_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
`ifdef FREQ_SWEEP_TRIANGLE_EN
            tri_q       <= tri_d;
`endif
        end
    end

    assign phase_inc_o = phase_inc_q;
    assign busy_o      = busy_q;
    assign step_o      = step_q;
    assign done_o      = done_q;
    assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// tb_freq_sweep_ctrl: randomized self-checking bench for freq_sweep_ctrl.
// The reference model builds the list of values a sweep visits from the
// stepping rules using wide integer arithmetic. Each cycle's expected
// outputs come from the position in that list (value index = cycle / (dwell+1)).
module tb_freq_sweep_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [31:0] f_start_i = '0;
    logic [31:0] f_stop_i = '0;
    logic [31:0] f_step_i = '0;
    logic [15:0] dwell_i = '0;
    logic        repeat_i = 1'b0;
`ifdef FREQ_SWEEP_TRIANGLE_EN
    logic        tri_i = 1'b0;
`endif
    logic [31:0] phase_inc_o;
    logic        busy_o, step_o, done_o, wrap_o;

    int n_chk = 0;
    int n_fail = 0;

    freq_sweep_ctrl #(.PHASE_W(32), .DWELL_W(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .f_start_i   (f_start_i),
        .f_stop_i    (f_stop_i),
        .f_step_i    (f_step_i),
        .dwell_i     (dwell_i),
        .repeat_i    (repeat_i),
`ifdef FREQ_SWEEP_TRIANGLE_EN
        .tri_i       (tri_i),
`endif
        .phase_inc_o (phase_inc_o),
        .busy_o      (busy_o),
        .step_o      (step_o),
        .done_o      (done_o),
        .wrap_o      (wrap_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Values a sweep visits, in order, ending with f_stop.
    task automatic build_vals(input logic [31:0] fs, input logic [31:0] fe,
                              input logic [31:0] st, output longint vals[$]);
        longint cur, nxt, s, e, d;
        bit     up;
        vals.delete();
        s = {32'b0, fs};
        e = {32'b0, fe};
        d = {32'b0, st};
        up = (e >= s);
        vals.push_back(s);
        cur = s;
        while (cur != e) begin
            nxt = up ? cur + d : cur - d;
            // Beyond the 32-bit range is also past f_stop, so no wrap is possible.
            if (d == 0 || (up ? nxt >= e : nxt <= e)) begin
                vals.push_back(e);
                cur = e;
            end else begin
                vals.push_back(nxt);
                cur = nxt;
            end
        end
    endtask

    // One sweep. stop_at < 0: let a single-shot sweep finish; otherwise
    // stop_i is raised during cycle stop_at (cycle 0 = first cycle showing f_start).
    task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fe,
                             input logic [31:0] st, input logic [15:0] dw,
                             input bit rep, input int stop_at);
        longint vals[$];
        longint exp_ph, last_ph;
        int     L, P;
        bit     ex_step, ex_wrap, ex_done, ex_busy;
        build_vals(fs, fe, st, vals);
        L = int'(dw) + 1;
        P = vals.size() * L;
        last_ph = 0;
        @(negedge clk_i);
        start_i = 1'b1; stop_i = 1'b0;
        f_start_i = fs; f_stop_i = fe; f_step_i = st; dwell_i = dw; repeat_i = rep;
        for (int c = 0; c < 100000; c++) begin
            @(negedge clk_i);
            if (stop_at >= 0 && c == stop_at + 1) begin
                chk("abort phase", {32'b0, phase_inc_o}, last_ph);
                chk("abort busy", busy_o, 0);
                chk("abort step", step_o, 0);
                chk("abort done", done_o, 0);
                chk("abort wrap", wrap_o, 0);
                break;
            end
            if (rep) begin
                exp_ph  = vals[(c % P) / L];
                ex_busy = 1; ex_done = 0;
                ex_step = (c % L == 0);
                ex_wrap = (c >= P) && (c % P == 0);
            end else if (c < P) begin
                exp_ph  = vals[c / L];
                ex_busy = 1; ex_done = 0; ex_wrap = 0;
                ex_step = (c % L == 0);
            end else begin
                exp_ph  = {32'b0, fe};
                ex_busy = 0; ex_step = 0; ex_wrap = 0;
                ex_done = (c == P);
            end
            chk($sformatf("phase c=%0d", c), {32'b0, phase_inc_o}, exp_ph);
            chk($sformatf("busy c=%0d", c), busy_o, ex_busy);
            chk($sformatf("step c=%0d", c), step_o, ex_step);
            chk($sformatf("done c=%0d", c), done_o, ex_done);
            chk($sformatf("wrap c=%0d", c), wrap_o, ex_wrap);
            last_ph = exp_ph;
            if (!rep && stop_at < 0 && c == P + 1) break;
            // Scramble config and fire stray starts while busy: all must be ignored.
            start_i   = (rep || c < P) && ($urandom_range(0, 3) == 0);
            f_start_i = $urandom; f_stop_i = $urandom; f_step_i = $urandom;
            dwell_i   = 16'($urandom); repeat_i = 1'($urandom);
            stop_i    = (c == stop_at);
        end
        start_i = 1'b0;
        stop_i  = 1'b0;
    endtask

    initial begin
        logic [31:0] fs, fe, st;
        logic [15:0] dw;
        longint      v[$];
        int          P;

        #2;
        chk("reset phase", phase_inc_o, 0);
        chk("reset busy", busy_o, 0);
        chk("reset step", step_o, 0);
        chk("reset done", done_o, 0);
        chk("reset wrap", wrap_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Directed cases from the plan.
        run_sweep(32'd100, 32'd130, 32'd10, 16'd2, 1'b0, -1);
        run_sweep(32'd1000, 32'd975, 32'd10, 16'd0, 1'b0, -1);
        run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 1'b0, -1);
        run_sweep(32'd5, 32'd7, 32'd1, 16'd0, 1'b1, 10);
        // Abort on the cycle 110's dwell expires (value 1, last dwell cycle).
        run_sweep(32'd100, 32'd130, 32'd10, 16'd2, 1'b0, 5);
        run_sweep(32'd40, 32'd60, 32'd0, 16'd1, 1'b0, -1);

        // Start together with stop in IDLE: stop wins.
        @(negedge clk_i);
        start_i = 1'b1; stop_i = 1'b1; f_start_i = 32'd9; f_stop_i = 32'd20;
        @(negedge clk_i);
        start_i = 1'b0; stop_i = 1'b0;
        chk("start+stop busy", busy_o, 0);
        chk("start+stop step", step_o, 0);

        // Asynchronous reset mid-sweep, checked before any clock edge.
        @(negedge clk_i);
        start_i = 1'b1; f_start_i = 32'd100; f_stop_i = 32'd130;
        f_step_i = 32'd10; dwell_i = 16'd2; repeat_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        chk("async rst phase", phase_inc_o, 0);
        chk("async rst busy", busy_o, 0);
        chk("async rst step", step_o, 0);
        chk("async rst done", done_o, 0);
        chk("async rst wrap", wrap_o, 0);
        #1 rst_i = 1'b0;
        run_sweep(32'd50, 32'd50, 32'd3, 16'd3, 1'b0, -1);

        // Randomized single-shot sweeps in a small range.
        for (int i = 0; i < 16; i++) begin
            fs = $urandom_range(0, 200);
            fe = $urandom_range(0, 200);
            st = $urandom_range(0, 30);
            dw = 16'($urandom_range(0, 3));
            run_sweep(fs, fe, st, dw, 1'b0, ($urandom_range(0, 4) == 0) ? 1 : -1);
        end
        // Near the top (overflow) and bottom (underflow) of the range.
        for (int i = 0; i < 4; i++) begin
            fs = 32'hFFFF_FF00 + $urandom_range(0, 255);
            fe = 32'hFFFF_FF00 + $urandom_range(0, 255);
            st = $urandom_range(1, 200);
            run_sweep(fs, fe, st, 16'($urandom_range(0, 2)), 1'b0, -1);
            fs = $urandom_range(0, 255);
            fe = $urandom_range(0, 255);
            run_sweep(fs, fe, st, 16'($urandom_range(0, 2)), 1'b0, -1);
        end
        // Continuous sweeps, stopped at a random point after a few wraps.
        for (int i = 0; i < 6; i++) begin
            fs = $urandom_range(0, 60);
            fe = $urandom_range(0, 60);
            st = $urandom_range(1, 15);
            dw = 16'($urandom_range(0, 2));
            build_vals(fs, fe, st, v);
            P = v.size() * (int'(dw) + 1);
            run_sweep(fs, fe, st, dw, 1'b1, int'($urandom_range(0, 3 * P)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
